div32_iter: RTL and testbench

//  Multi-cycle iterative integer divider for the EX stage of the pipelined CPU (DIV/DIVU -> HI/LO).

---
 rtl/div32_iter_pkg.sv | 5 +
 rtl/div32_iter_step.sv | 17 +
 rtl/div32_iter.sv | 109 ++++++++++
 tb/tb_div32_iter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/div32_iter_pkg.sv
// div32_iter_pkg: shared width and FSM state encoding for the iterative divider.
package div32_iter_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/div32_iter_step.sv
// div32_iter_step: one restoring-division step (shift, trial subtract, restore).
module div32_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] diff;
  logic             borrow;
  assign diff     = {rem, q_msb} - {2'b0, divisor};
  assign borrow   = diff[WIDTH+1];
  assign q_bit    = ~borrow;
  assign rem_next = borrow ? {rem[WIDTH-1:0], q_msb} : diff[WIDTH:0];
endmodule

// File: rtl/div32_iter.sv
// div32_iter: multi-cycle restoring divider (DIV/DIVU) with start/busy/done handshake.
module div32_iter
  import div32_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d, step_rem;
  logic [WIDTH-1:0] q_q, q_d, dvsr_q, dvsr_d, quo_q, quo_d, remo_q, remo_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d, step_q;
  logic             sd, sv;
  assign sd = is_signed & dividend[WIDTH-1];
  assign sv = is_signed & divisor[WIDTH-1];
  div32_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q_msb    (q_q[WIDTH-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: if (start && !flush) begin
        rem_d   = '0;
        q_d     = sd ? -dividend : dividend;
        dvsr_d  = sv ? -divisor : divisor;
        qneg_d  = sd ^ sv;
        rneg_d  = sd;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = (divisor == '0) ? S_DONE : S_CALC;
        if (divisor == '0) begin
          quo_d  = '1;
          remo_d = dividend;
          dbz_d  = 1'b1;
        end
      end
      S_CALC: if (flush) state_d = S_IDLE;
      else begin
        rem_d   = step_rem;
        q_d     = {q_q[WIDTH-2:0], step_q};
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == '0) ? S_FIX : S_CALC;
      end
      S_FIX: if (flush) state_d = S_IDLE;
      else begin
        quo_d   = qneg_q ? -q_q : q_q;
        remo_d  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div32_iter.sv
// tb_div32_iter: directed checks of latency, signed/unsigned results, div-by-zero, flush and reset.
module tb_div32_iter;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_signed = 1'b0, flush = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int total = 0, bad = 0;
  int lat, bcnt;
  bit bdone;

  div32_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .flush(flush), .busy(busy),
    .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Entered just after a rising edge in IDLE; leaves just after the edge ending the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input bit hold,
                        output int l, output int bc, output bit bd);
    dividend = a; divisor = b; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    l = -1; bc = 0; bd = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin l = c; bd = busy; break; end
      if (busy) bc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quot got %h want 0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL reset_rem got %h want 0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu();
    run_op(32'd100, 32'd7, 1'b0, 1'b0, lat, bcnt, bdone);
    total++; if (lat != 34) begin bad++; $display("FAIL divu_latency got %0d want 34", lat); end
    total++; if (bcnt != 33) begin bad++; $display("FAIL divu_busy_cycles got %0d want 33", bcnt); end
    total++; if (bdone !== 1'b0) begin bad++; $display("FAIL divu_busy_at_done got %b want 0", bdone); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL divu_quot got %h want %h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL divu_rem got %h want %h", remainder, 32'd2); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL divu_dbz got %b want 0", div_by_zero); end
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat, bcnt, bdone);
    total++; if (lat != 34) begin bad++; $display("FAIL sneg_latency got %0d want 34", lat); end
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sneg_quot got %h want fffffffd", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sneg_rem got %h want ffffffff", remainder); end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, lat, bcnt, bdone);
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sdivneg_quot got %h want fffffffd", quotient); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL sdivneg_rem got %h want 00000001", remainder); end
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0, lat, bcnt, bdone);
    total++; if (quotient !== 32'd3) begin bad++; $display("FAIL sboth_quot got %h want 00000003", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sboth_rem got %h want ffffffff", remainder); end
  endtask

  task automatic test_div_zero();
    run_op(32'h1234_5678, 32'h0, 1'b0, 1'b0, lat, bcnt, bdone);
    total++; if (lat != 1) begin bad++; $display("FAIL dz_latency got %0d want 1", lat); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quot got %h want ffffffff", quotient); end
    total++; if (remainder !== 32'h1234_5678) begin bad++; $display("FAIL dz_rem got %h want 12345678", remainder); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
  endtask

  task automatic test_overflow();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, bcnt, bdone);
    total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL ovf_quot got %h want 80000000", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL ovf_rem got %h want 00000000", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL ovf_dbz got %b want 0", div_by_zero); end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, lat, bcnt, bdone);
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL umax_quot got %h want ffffffff", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL umax_rem got %h want 00000000", remainder); end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcnt, bdone);
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL ubig_quot got %h want 00000000", quotient); end
    total++; if (remainder !== 32'h8000_0000) begin bad++; $display("FAIL ubig_rem got %h want 80000000", remainder); end
  endtask

  task automatic test_flush();
    int seen;
    dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got %b want 0", busy); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_done got %0d active cycles want 0", seen); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL flush_hold_quot got %h want 00000000", quotient); end
    total++; if (remainder !== 32'h8000_0000) begin bad++; $display("FAIL flush_hold_rem got %h want 80000000", remainder); end
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle_drop got busy=%b done=%b want 0 0", busy, done); end
    run_op(32'd9, 32'd3, 1'b0, 1'b0, lat, bcnt, bdone);
    total++; if (lat != 34) begin bad++; $display("FAIL after_flush_latency got %0d want 34", lat); end
    total++; if (quotient !== 32'd3) begin bad++; $display("FAIL after_flush_quot got %h want 00000003", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL after_flush_rem got %h want 00000000", remainder); end
  endtask

  task automatic test_back_to_back();
    run_op(32'd1000, 32'd10, 1'b0, 1'b1, lat, bcnt, bdone);
    total++; if (lat != 34) begin bad++; $display("FAIL held_start_latency got %0d want 34", lat); end
    total++; if (quotient !== 32'd100) begin bad++; $display("FAIL held_start_quot got %h want 00000064", quotient); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL held_start_rem got %h want 00000000", remainder); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL start_in_done_ignored got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int seen;
    dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got busy=%b done=%b want 0 0", busy, done); end
    total++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL rst_mid_outs got q=%h r=%h dz=%b want 0 0 0", quotient, remainder, div_by_zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", seen); end
    @(posedge clk); #1;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat, bcnt, bdone);
    total++; if (lat != 34 || quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL rst_mid_recover got lat=%0d q=%h want 34 fffffffd", lat, quotient); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
